// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM state encoding
// and default operand width.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_subtractor.sv
// Combinational 1-bit subtractor slice: d = x - y - bin, with borrow-out.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    always_comb begin
        d    = x ^ y ^ bin;
        bout = (~x & y) | (~(x ^ y) & bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b - bin), LSB first, with
// valid/ready handshakes on operands and result.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_diff;
    logic             r_br;
    logic             r_bout;
    logic             w_d;
    logic             w_br_next;
    logic             w_last;

    full_subtractor u_slice (
        .x    (r_a[0]),
        .y    (r_b[0]),
        .bin  (r_br),
        .d    (w_d),
        .bout (w_br_next)
    );

    assign w_last = (r_cnt == LAST_BIT);

    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next_state = ST_SHIFT;
            end
            ST_SHIFT: begin
                busy = 1'b1;
                if (w_last) w_next_state = ST_DONE;
            end
            ST_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_diff  <= '0;
            r_br    <= 1'b0;
            r_bout  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a    <= a;
                        r_b    <= b;
                        r_br   <= bin;
                        r_cnt  <= '0;
                        r_diff <= '0;
                    end
                end
                ST_SHIFT: begin
                    r_a    <= {1'b0, r_a[WIDTH-1:1]};
                    r_b    <= {1'b0, r_b[WIDTH-1:1]};
                    r_diff <= {w_d, r_diff[WIDTH-1:1]};
                    r_br   <= w_br_next;
                    // Hold the counter at the terminal value so it never wraps.
                    if (w_last) begin
                        r_bout <= w_br_next;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign diff = r_diff;
    assign bout = r_bout;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor against an arithmetic reference.
module tb_serial_subtractor;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         bin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] diff;
    logic         bout;
    logic         busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: (W+1)-bit unsigned subtraction; the top bit is the borrow.
    function automatic logic [W:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic bi);
        return {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bi};
    endfunction

    // Present operands and hold in_valid until accepted; acc = acceptance edge number.
    task automatic start_op(input logic [W-1:0] xa, input logic [W-1:0] xb,
                            input logic xbi, output int acc);
        int k = 0;
        a = xa; b = xb; bin = xbi; in_valid = 1'b1;
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        acc = cyc + 1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Wait (bounded) for out_valid; edge = number of the edge it rose after.
    task automatic wait_valid(output int edge_n, output bit ok);
        int k = 0;
        while (!out_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        ok = out_valid;
        edge_n = cyc;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk); @(negedge clk);
        n_tests++;
        if ({in_ready, out_valid, busy, bout, diff} !== {1'b1, 1'b0, 1'b0, 1'b0, {W{1'b0}}}) begin
            n_fail++;
            $display("FAIL reset: rdy=%b vld=%b busy=%b bout=%b diff=%h, want rdy=1 vld=0 busy=0 bout=0 diff=00",
                     in_ready, out_valid, busy, bout, diff);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int acc, e; bit ok;
        logic [W:0] exp_r;
        exp_r = ref_sub(8'h5A, 8'h23, 1'b0);
        start_op(8'h5A, 8'h23, 1'b0, acc);
        n_tests++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_busy: busy=%b in_ready=%b, want 1 0", busy, in_ready);
        end
        wait_valid(e, ok);
        n_tests++;
        if (!ok || (e - acc) != int'(W)) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d edges (valid=%b), want %0d", e - acc, ok, W);
        end
        n_tests++;
        if ({bout, diff} !== exp_r || exp_r !== 9'h037) begin
            n_fail++;
            $display("FAIL basic_result: got bout=%b diff=%h, want bout=0 diff=37", bout, diff);
        end
        consume();
    endtask

    task automatic test_underflow();
        int acc, e; bit ok;
        logic [W-1:0] xa [2] = '{8'h10, 8'h00};
        logic [W-1:0] xb [2] = '{8'h20, 8'h00};
        logic         xi [2] = '{1'b0, 1'b1};
        logic [W:0]   want [2] = '{9'h1F0, 9'h1FF};
        for (int i = 0; i < 2; i++) begin
            start_op(xa[i], xb[i], xi[i], acc);
            wait_valid(e, ok);
            n_tests++;
            if (!ok || {bout, diff} !== want[i] || ref_sub(xa[i], xb[i], xi[i]) !== want[i]) begin
                n_fail++;
                $display("FAIL underflow_%0d: got bout=%b diff=%h valid=%b, want bout=%b diff=%h",
                         i, bout, diff, ok, want[i][W], want[i][W-1:0]);
            end
            consume();
        end
    endtask

    task automatic test_back_to_back();
        int acc1, acc2, e; bit ok;
        int k;
        out_ready = 1'b1;
        a = 8'hFF; b = 8'h01; bin = 1'b0; in_valid = 1'b1;
        acc1 = cyc + 1;
        @(negedge clk);
        a = 8'h80; b = 8'h80; bin = 1'b1;
        wait_valid(e, ok);
        n_tests++;
        if (!ok || {bout, diff} !== 9'h0FE) begin
            n_fail++;
            $display("FAIL b2b_first: got bout=%b diff=%h, want bout=0 diff=fe", bout, diff);
        end
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_no_overlap: in_ready=%b in DONE, want 0", in_ready);
        end
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        acc2 = cyc + 1;
        n_tests++;
        if (acc2 - acc1 != int'(W) + 2) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %0d cycles, want %0d", acc2 - acc1, W + 2);
        end
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid(e, ok);
        n_tests++;
        if (!ok || {bout, diff} !== ref_sub(8'h80, 8'h80, 1'b1)) begin
            n_fail++;
            $display("FAIL b2b_second: got bout=%b diff=%h, want bout=1 diff=ff", bout, diff);
        end
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int acc, e; bit ok, bad;
        logic [W:0] exp_r;
        exp_r = ref_sub(8'h3C, 8'h7D, 1'b1);
        start_op(8'h3C, 8'h7D, 1'b1, acc);
        wait_valid(e, ok);
        bad = !ok;
        for (int i = 0; i < 5; i++) begin
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || {bout, diff} !== exp_r) bad = 1'b1;
            @(negedge clk);
        end
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL backpressure_hold: vld=%b rdy=%b bout=%b diff=%h, want 1 0 %b %h",
                     out_valid, in_ready, bout, diff, exp_r[W], exp_r[W-1:0]);
        end
        consume();
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || {bout, diff} !== exp_r) begin
            n_fail++;
            $display("FAIL backpressure_release: vld=%b rdy=%b bout=%b diff=%h, want 0 1 %b %h",
                     out_valid, in_ready, bout, diff, exp_r[W], exp_r[W-1:0]);
        end
    endtask

    task automatic test_reset_mid();
        int acc; bit seen;
        start_op(8'hAA, 8'h55, 1'b0, acc);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_tests++;
        if ({in_ready, out_valid, busy, bout, diff} !== {1'b1, 1'b0, 1'b0, 1'b0, {W{1'b0}}}) begin
            n_fail++;
            $display("FAIL reset_mid: rdy=%b vld=%b busy=%b bout=%b diff=%h, want 1 0 0 0 00",
                     in_ready, out_valid, busy, bout, diff);
        end
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (out_valid) seen = 1'b1;
            @(negedge clk);
        end
        n_tests++;
        if (seen) begin
            n_fail++;
            $display("FAIL reset_mid_novalid: out_valid=1 after abort, want 0");
        end
    endtask

    task automatic test_idle_protection();
        int acc, e; bit ok;
        logic [W-1:0] xa, xb;
        logic xi;
        logic [W:0] exp_r;
        for (int t = 0; t < 12; t++) begin
            xa = W'($urandom); xb = W'($urandom); xi = 1'($urandom);
            exp_r = ref_sub(xa, xb, xi);
            start_op(xa, xb, xi, acc);
            in_valid = 1'b1;
            e = 0;
            while (!out_valid && e < 100) begin
                a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
                @(negedge clk);
                e++;
            end
            in_valid = 1'b0;
            n_tests++;
            if (!out_valid || {bout, diff} !== exp_r) begin
                n_fail++;
                $display("FAIL protect_%0d: a=%h b=%h bin=%b got bout=%b diff=%h, want %b %h",
                         t, xa, xb, xi, bout, diff, exp_r[W], exp_r[W-1:0]);
            end
            for (int d = 0; d < int'($urandom_range(0, 3)); d++) @(negedge clk);
            consume();
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_underflow();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_idle_protection();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial N-bit subtractor computing `diff = a - b - bin` one bit per clock, LSB first, with a borrow flop carried between bit slices. It is the inverse-operation companion to the team's combinational full-adder datapath. Operands arrive over a valid/ready input handshake and the result leaves over a valid/ready output handshake, so the block can sit between a register-file read port and a result FIFO in area-constrained arithmetic paths.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range 2..32.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `in_valid` input 1: operands on `a`, `b`, `bin` are valid.
- `in_ready` output 1: block can accept operands; high only in IDLE.
- `a` input WIDTH: minuend.
- `b` input WIDTH: subtrahend.
- `bin` input 1: borrow-in.
- `out_valid` output 1: `diff` and `bout` are valid; high only in DONE.
- `out_ready` input 1: consumer accepts the result.
- `diff` output WIDTH: registered difference, `a - b - bin` mod 2^WIDTH.
- `bout` output 1: registered borrow-out; 1 when `a < b + bin` unsigned.
- `busy` output 1: high in SHIFT or DONE.

## Operation
- States:
  - IDLE: `in_ready=1`.
  - SHIFT: one bit processed per cycle.
  - DONE: `out_valid=1`.
- **Transitions:**
  - IDLE→SHIFT on `in_valid & in_ready`. Capture `a`, `b` into shift registers, `bin` into the borrow flop, clear the bit counter and the `diff` shift register.
  - SHIFT→SHIFT while counter < WIDTH-1. SHIFT→DONE on the cycle the counter equals WIDTH-1.
  - DONE→IDLE on `out_valid & out_ready`. DONE holds indefinitely while `out_ready=0`.
- **Bit slice per SHIFT cycle**, with `x=a_sr[0]`, `y=b_sr[0]`, `br` = borrow flop:
  - `d = x^y^br`
  - `br_next = (~x & y) | (~(x^y) & br)`
- **Register updates per SHIFT cycle:**
  - `a_sr` and `b_sr` shift right by one.
  - `d` shifts into `diff` at the MSB; the existing contents move right.
  - `br` takes `br_next`.
  - The counter increments.
- On the final SHIFT cycle, `bout` is loaded with `br_next`.
- **Output stability:** `diff` and `bout` change only during SHIFT. They hold the last result through DONE and IDLE until the next operation's first SHIFT cycle.
- **No overlap:** the block does not accept in the same cycle it completes. `in_ready` is low in DONE even when `out_ready=1`.
- **Inputs outside IDLE:** `a`, `b` and `bin` are ignored while `in_ready=0`.

## Timing
- **Reset values** (sampled with `rst=1` at a rising edge):
  - State = IDLE.
  - `in_ready=1`.
  - `out_valid=0`, `busy=0`.
  - `diff=0`, `bout=0`, counter=0, borrow flop=0.
- **Reset priority:** `rst` overrides every other input on that edge.
- **Reset mid-operation** (SHIFT or DONE): the operation is aborted. `out_valid` never asserts for it, and `in_ready=1` in the cycle after the reset edge.
- **Latency:** acceptance edge E. SHIFT occupies the cycles following edges E..E+WIDTH-1. `out_valid` is high starting the cycle after edge E+WIDTH, i.e. WIDTH cycles after acceptance.
- **Throughput:** at best one result per WIDTH+2 cycles — accept, WIDTH shifts, one DONE cycle, with `out_ready` held high.
- **Handshake outputs:** `in_ready` and `out_valid` are pure state decodes with no combinational path from `in_valid` or `out_ready`.
- **Counter width:** $clog2(WIDTH) bits. The terminal compare is against WIDTH-1, so the counter never wraps in normal operation.

## Structure
- Shared package `serial_arith_pkg` holds:
  - the state encoding localparams (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2);
  - the default width constant.
- One sub-module, `full_subtractor`:
  - combinational 1-bit slice with ports `x`, `y`, `bin`, `d`, `bout`;
  - instantiated once, driven from the shift-register LSBs and the borrow flop.
- All state — FSM, counter, shift registers, borrow flop, `diff`, `bout` — lives in the top level.

## Test plan
- **Basic subtract**, WIDTH=8: `a=8'h5A`, `b=8'h23`, `bin=0` → `diff=8'h37`, `bout=0`; `out_valid` rises exactly 8 cycles after the acceptance edge.
- **Underflow:** `a=8'h10`, `b=8'h20`, `bin=0` → `diff=8'hF0`, `bout=1`. Then `a=8'h00`, `b=8'h00`, `bin=1` → `diff=8'hFF`, `bout=1`.
- **Back-to-back** with `out_ready=1`:
  - `a=8'hFF`, `b=8'h01`, `bin=0` → `8'hFE`, `bout=0`;
  - then `a=8'h80`, `b=8'h80`, `bin=1` → `8'hFF`, `bout=1`;
  - second acceptance occurs exactly WIDTH+2 cycles after the first.
- **Output backpressure:** hold `out_ready=0` for 5 cycles in DONE → `out_valid`, `diff` and `bout` stay stable and `in_ready` stays 0 throughout. Then release `out_ready` → IDLE the next cycle.
- **Reset mid-SHIFT:** assert `rst` for one edge 3 cycles after accepting `a=8'hAA`, `b=8'h55` → `out_valid` never asserts, `diff=0`, `bout=0`, and `in_ready=1` the following cycle.
- **Idle protection:** toggle `a` and `b` while `busy=1` → the result matches the operands captured at acceptance.
